// File: rtl/frame_dump_ctrl.sv
// Button-triggered dump of one downsampled frame to the UART.
// Sends a 2-byte sync header, then WIDTH x HEIGHT pixels row-major.
module frame_dump_ctrl #(
  parameter int WIDTH = 40,
  parameter int HEIGHT = 30,
  parameter int X_BITS = 6,
  parameter int Y_BITS = 5,
  parameter int READ_LATENCY = 1,
  parameter int DEBOUNCE_BITS = 14,
  parameter int HOLDOFF_BITS = 13,
  parameter logic [7:0] SYNC0 = 8'hA5,
  parameter logic [7:0] SYNC1 = 8'h5A
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              btn,
  input  logic              abort,
  output logic [X_BITS-1:0] read_x,
  output logic [Y_BITS-1:0] read_y,
  input  logic [7:0]        read_data,
  input  logic              uart_busy,
  output logic              uart_write,
  output logic [7:0]        uart_data,
  output logic              dump_active,
  output logic              dump_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_RD_WAIT,
    S_PIX
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY);
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(HEIGHT - 1);

  state_t state, state_d;

  logic btn_s0, btn_s1;
  logic armed;
  logic [DEBOUNCE_BITS-1:0] deb_cnt;
  logic [HOLDOFF_BITS-1:0] hold_cnt;
  logic [1:0] lat_cnt, lat_d;

  logic [X_BITS-1:0] x_d;
  logic [Y_BITS-1:0] y_d;
  logic [7:0] data_d;
  logic write_d, done_d, active_d;

  logic deb_sat, hold_sat, trigger;
  logic send_ok, abort_ok, last_x, last_y;

  assign deb_sat  = &deb_cnt;
  assign hold_sat = &hold_cnt;
  assign trigger  = deb_sat & armed & (state == S_IDLE);
  assign send_ok  = hold_sat & ~uart_busy & ~uart_write;
  assign abort_ok = abort & ~uart_write;
  assign last_x   = (read_x == X_LAST);
  assign last_y   = (read_y == Y_LAST);

  // Button synchroniser, debounce, re-arm and inter-byte holdoff
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      btn_s0   <= 1'b0;
      btn_s1   <= 1'b0;
      deb_cnt  <= '0;
      armed    <= 1'b1;
      hold_cnt <= '0;
    end else begin
      btn_s0 <= btn;
      btn_s1 <= btn_s0;
      if (!btn_s1) begin
        deb_cnt <= '0;
      end else if (!deb_sat) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      if (trigger) begin
        armed <= 1'b0;
      end else if (!btn_s1) begin
        armed <= 1'b1;
      end
      if (uart_busy || uart_write) begin
        hold_cnt <= '0;
      end else if (!hold_sat) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; abort wins over advancing but not over a write
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (trigger) state_d = S_HDR0;
      end
      S_HDR0: begin
        if (abort_ok) state_d = S_IDLE;
        else if (send_ok) state_d = S_HDR1;
      end
      S_HDR1: begin
        if (abort_ok) state_d = S_IDLE;
        else if (send_ok) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (abort_ok) state_d = S_IDLE;
        else if (lat_cnt == 2'd0) state_d = S_PIX;
      end
      S_PIX: begin
        if (abort_ok) state_d = S_IDLE;
        else if (send_ok) state_d = (last_x && last_y) ? S_IDLE : S_RD_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and latency counter
  always_comb begin
    write_d  = 1'b0;
    done_d   = 1'b0;
    data_d   = uart_data;
    x_d      = read_x;
    y_d      = read_y;
    lat_d    = lat_cnt;
    active_d = trigger | (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (trigger) begin
          x_d = '0;
          y_d = '0;
        end
      end
      S_HDR0: begin
        if (send_ok) begin
          write_d = 1'b1;
          data_d  = SYNC0;
        end
      end
      S_HDR1: begin
        if (send_ok) begin
          write_d = 1'b1;
          data_d  = SYNC1;
          lat_d   = LAT_INIT;
        end
      end
      S_RD_WAIT: begin
        if (lat_cnt == 2'd0) data_d = read_data;
        else lat_d = lat_cnt - 2'd1;
      end
      S_PIX: begin
        if (send_ok) begin
          write_d = 1'b1;
          if (!abort_ok) begin
            lat_d = LAT_INIT;
            if (last_x && last_y) begin
              done_d = 1'b1;
              x_d    = '0;
              y_d    = '0;
            end else if (last_x) begin
              x_d = '0;
              y_d = read_y + Y_BITS'(1);
            end else begin
              x_d = read_x + X_BITS'(1);
            end
          end
        end
      end
      default: begin
        write_d = 1'b0;
      end
    endcase
  end

  // Output and latency registers
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      read_x      <= '0;
      read_y      <= '0;
      uart_write  <= 1'b0;
      uart_data   <= '0;
      dump_active <= 1'b0;
      dump_done   <= 1'b0;
      lat_cnt     <= '0;
    end else begin
      read_x      <= x_d;
      read_y      <= y_d;
      uart_write  <= write_d;
      uart_data   <= data_d;
      dump_active <= active_d;
      dump_done   <= done_d;
      lat_cnt     <= lat_d;
    end
  end

endmodule

// File: doc/frame_dump_ctrl.md
Name: frame_dump_ctrl

Overview:
- Sequencer that dumps one downsampled frame from the downsample read port to the UART transmitter when the user presses a button.
- Sits between the downsample buffer (read side, system clock domain) and the uart block.
- Debounces the trigger, emits a 2-byte sync header, then scans WIDTH x HEIGHT pixels row-major and handshakes each byte with uart_busy.

Parameters:
- WIDTH, 40, pixels per row sent
- HEIGHT, 30, rows sent
- X_BITS, 6, width of read_x
- Y_BITS, 5, width of read_y
- READ_LATENCY, 1, cycles from read_x/read_y change to valid read_data (1..3)
- DEBOUNCE_BITS, 14, debounce counter width; press accepted after 2^DEBOUNCE_BITS-1 stable-high cycles
- HOLDOFF_BITS, 13, inter-byte idle counter width
- SYNC0, 8'hA5, first header byte
- SYNC1, 8'h5A, second header byte

Ports:
- clk  in  1  system clock (12 MHz)
- areset_n  in  1  reset, asynchronous, active-low
- btn  in  1  raw trigger button, active-high, asynchronous
- abort  in  1  synchronous abort request
- read_x  out  X_BITS  downsample read column
- read_y  out  Y_BITS  downsample read row
- read_data  in  8  downsample read data
- uart_busy  in  1  uart transmitting
- uart_write  out  1  one-cycle byte strobe to uart
- uart_data  out  8  byte to transmit, stable while uart_write=1
- dump_active  out  1  high from trigger acceptance until return to IDLE
- dump_done  out  1  one-cycle pulse when the last pixel byte is written

Behaviour:
- Reset (areset_n=0, async): state=IDLE; read_x=0, read_y=0, uart_write=0, uart_data=0, dump_active=0, dump_done=0; debounce, holdoff and latency counters=0; armed=1. Reset mid-dump discards the dump. Nothing resumes.
- btn synchronisation: two flops.
- Debounce counter: clears while the synced btn is 0, otherwise saturates.
- Trigger: counter saturated AND armed AND state==IDLE. Trigger clears armed. armed sets again only when the synced btn reads 0.
  - Holding the button gives exactly one dump.
  - A press during a dump never starts a second one.
- Holdoff counter: clears while uart_busy=1 and on every uart_write cycle; otherwise saturates.
- Send condition: holdoff saturated AND uart_busy=0 AND uart_write=0.
- States:
  - IDLE: waits for trigger. On trigger: read_x=0, read_y=0, dump_active=1, go to HDR0.
  - HDR0: on send condition, uart_write=1 with uart_data=SYNC0, go to HDR1.
  - HDR1: on send condition, write SYNC1, go to RD_WAIT. Latency counter is loaded with READ_LATENCY.
  - RD_WAIT: decrements the latency counter. At 0, latches read_data into uart_data and goes to PIX.
  - PIX: on send condition, uart_write=1 and the address advances in the same cycle:
    - If read_x==WIDTH-1 and read_y==HEIGHT-1: dump_done=1 for that cycle, go to IDLE, dump_active=0 on the next cycle, read_x/read_y return to 0.
    - Else if read_x==WIDTH-1: read_x=0, read_y+1, go to RD_WAIT.
    - Else: read_x+1, go to RD_WAIT.
- uart_write is always exactly one cycle. There are never two writes within HOLDOFF saturation time.
- Total bytes per dump: 2+WIDTH*HEIGHT (1202 with defaults). Pixel order is row-major starting at (0,0).
- read_x/read_y change only on PIX writes or on trigger. They never exceed WIDTH-1/HEIGHT-1.
- Abort:
  - Sampled only in HDR0/HDR1/RD_WAIT/PIX while no write is pending that cycle.
  - Effect: go to IDLE, dump_active=0, no dump_done. A byte already strobed completes normally in the uart.
  - Abort and send condition in the same cycle: the write happens, then the next state is IDLE.
- uart_busy held high indefinitely: the block waits without timeout. dump_active stays 1.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Reset, then btn high for 2^14+10 cycles, uart model busy 100 cycles per byte, read_data=x+8*y -> exactly 1202 strobes: A5, 5A, then bytes 0,1,..,39, 8,..; dump_done pulses once, coincident with the strobe carrying byte 39+8*29 mod 256; dump_active falls the next cycle.
- btn bounce (toggle every 100 cycles for 5000 cycles, then low) -> no uart_write, dump_active stays 0.
- btn held high through an entire dump and 10000 cycles beyond -> exactly one dump; release and re-press -> second dump starts.
- READ_LATENCY=2, read model with 2-cycle registered output -> every pixel byte matches the (x,y) driven 2 cycles earlier; no stale byte at row wrap (x 39 to 0).
- abort asserted at the 500th pixel strobe cycle -> that byte is sent, no further strobes, dump_done never pulses, read_x/read_y hold; a new trigger restarts at the header with (0,0).
- areset_n low mid-row (x=17, y=3) for 1 cycle -> all outputs 0 immediately; no strobes afterwards until a new debounced press.
